// File: rtl/maclaurin_pkg.sv
// maclaurin_pkg: shared function codes, datapath widths and scheduler state encoding
package maclaurin_pkg;
  localparam logic [1:0] FN_EXP = 2'd0;
  localparam logic [1:0] FN_SIN = 2'd1;
  localparam logic [1:0] FN_COS = 2'd2;
  localparam logic [1:0] FN_LN  = 2'd3;
  localparam int X_W = 16;
  localparam int R_W = 18;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/maclaurin_job_scheduler_rr_arbiter.sv
// rr_arbiter: circular priority search from ptr_i+1 over req_i, gated by en_i; ports req_i, ptr_i, en_i in, gnt_o one-hot, idx_o encoded out
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);
  int   j;
  logic hit;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    hit = 1'b0;
    j = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (en_i && !hit && req_i[j]) begin
        hit = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = IW'(j);
      end
    end
  end
endmodule

// File: rtl/maclaurin_job_scheduler.sv
// maclaurin_job_scheduler: round-robin job scheduler for one shared Maclaurin engine (req_* in, eng_* out/in, rsp_* out, busy); MACLAUR_TIMEOUT_EN adds a WAIT watchdog
module maclaurin_job_scheduler
  import maclaurin_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_func,
  input  logic [16*NREQ-1:0] req_x,
  output logic              eng_start,
  output logic [1:0]        eng_func,
  output logic [X_W-1:0]    eng_x,
  input  logic [R_W-1:0]    eng_r,
  input  logic              eng_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [1:0]        rsp_func,
  output logic [R_W-1:0]    rsp_r,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, g_idx;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  id_q, id_d;
  logic [1:0]      func_q, func_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [R_W-1:0]  r_q, r_d;
  logic            err_q, err_d, done_q, done_edge, timeout;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .en_i (state_q == IDLE && rst),
    .gnt_o(gnt),
    .idx_o(g_idx)
  );
  assign done_edge = eng_done & ~done_q;
`ifdef MACLAUR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (state_q == ISSUE) ? '0 : (state_q == WAIT) ? cnt_q + 1'b1 : cnt_q;
  assign timeout = (state_q == WAIT) && (cnt_d == CW'(TIMEOUT_CYC));
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    func_d = func_q;
    x_d = x_q;
    r_d = r_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = ISSUE;
        ptr_d = g_idx;
        id_d = IDW'(g_idx);
        func_d = req_func[2*int'(g_idx) +: 2];
        x_d = req_x[X_W*int'(g_idx) +: X_W];
      end
      ISSUE: state_d = WAIT;
      WAIT: if (done_edge) begin
        state_d = RESP;
        r_d = eng_r;
        err_d = 1'b0;
      end else if (timeout) begin
        state_d = RESP;
        r_d = '0;
        err_d = 1'b1;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      ptr_q <= IW'(NREQ - 1);
      id_q <= '0;
      func_q <= '0;
      x_q <= '0;
      r_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      func_q <= func_d;
      x_q <= x_d;
      r_q <= r_d;
      err_q <= err_d;
      done_q <= eng_done;
    end
  assign req_ready = gnt;
  assign eng_start = state_q == ISSUE;
  assign eng_func = func_q;
  assign eng_x = x_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_id = id_q;
  assign rsp_func = func_q;
  assign rsp_r = r_q;
  assign rsp_err = err_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_maclaurin_job_scheduler.sv
// tb_maclaurin_job_scheduler: directed table and corner-sequence bench for the job scheduler
module tb_maclaurin_job_scheduler;
  logic        clk = 1'b0, rst = 1'b0;
  logic [1:0]  req_valid = '0, req_ready;
  logic [3:0]  req_func = '0;
  logic [31:0] req_x = '0;
  logic        eng_start, eng_done = 1'b0, rsp_valid, rsp_ready = 1'b1, rsp_err, busy;
  logic [1:0]  eng_func, rsp_func;
  logic [15:0] eng_x;
  logic [17:0] eng_r = '0, rsp_r;
  logic [0:0]  rsp_id;
  int checks = 0, failures = 0, n_start = 0;
  logic [1:0] grants[$];
  logic [2:0] rsps[$];

  maclaurin_job_scheduler #(.NREQ(2), .IDW(1), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_x(req_x), .eng_start(eng_start), .eng_func(eng_func),
    .eng_x(eng_x), .eng_r(eng_r), .eng_done(eng_done), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_func(rsp_func), .rsp_r(rsp_r),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (eng_start) n_start++;
    if (|(req_ready & req_valid)) grants.push_back(req_ready);
    if (rsp_valid && rsp_ready) rsps.push_back({rsp_id, rsp_func});
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench watchdog expired");
  end

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  f0, f1;
    logic [15:0] x0, x1;
    logic [17:0] r;
    int          dly;
    logic [1:0]  eid;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_start();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (eng_start) break;
    end
    chk("start_seen", eng_start, 1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) break;
    end
    chk("rsp_seen", rsp_valid, 1);
  endtask

  task automatic run_job(input vec_t t, input bit keep);
    logic [1:0]  ef;
    logic [15:0] ex;
    int base;
    ef = t.eid[0] ? t.f1 : t.f0;
    ex = t.eid[0] ? t.x1 : t.x0;
    base = n_start;
    @(posedge clk); #1;
    req_valid = t.v;
    req_func = {t.f1, t.f0};
    req_x = {t.x1, t.x0};
    #1 chk("req_ready", req_ready, 32'd1 << t.eid);
    @(posedge clk); #1;
    req_valid = '0;
    chk("start_t1", eng_start, 1);
    chk("eng_func", eng_func, ef);
    chk("eng_x", eng_x, ex);
    repeat (t.dly) @(posedge clk);
    #1 chk("rsp_early", rsp_valid, 0);
    eng_r = t.r;
    eng_done = 1'b1;
    @(posedge clk); #1;
    chk("rsp_valid_d1", rsp_valid, 1);
    chk("rsp_id", rsp_id, t.eid);
    chk("rsp_func", rsp_func, ef);
    chk("rsp_r", rsp_r, t.r);
    chk("rsp_err", rsp_err, 0);
    @(posedge clk); #1;
    chk("rsp_drop", rsp_valid, 0);
    chk("idle_busy", busy, 0);
    chk("one_start", n_start - base, 1);
    if (!keep) eng_done = 1'b0;
  endtask

  vec_t tbl[6];
  int   base, bad;

  initial begin
    tbl[0] = '{2'b01, 2'd1, 2'd0, 16'h1000, 16'h0000, 18'h0ABCD, 20, 2'd0};
    tbl[1] = '{2'b11, 2'd2, 2'd3, 16'h2000, 16'h2100, 18'h3FFFF, 3, 2'd1};
    tbl[2] = '{2'b11, 2'd2, 2'd3, 16'h2001, 16'h2101, 18'h00001, 1, 2'd0};
    tbl[3] = '{2'b10, 2'd1, 2'd0, 16'h0000, 16'hFFFF, 18'h20000, 5, 2'd1};
    tbl[4] = '{2'b01, 2'd3, 2'd1, 16'h7FFF, 16'h1234, 18'h12345, 2, 2'd0};
    tbl[5] = '{2'b01, 2'd0, 2'd2, 16'h8000, 16'h4321, 18'h00000, 4, 2'd0};

    req_valid = 2'b11;
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_rsp_fields", {rsp_id, rsp_func, rsp_r, rsp_err, eng_func, eng_x}, 0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 6; i++) run_job(tbl[i], i == 5);

    // stale done: level still high from the last table job
    @(posedge clk); #1;
    req_valid = 2'b01; req_func = 4'b0010; req_x = 32'h0000_2222;
    @(posedge clk); #1;
    req_valid = '0;
    chk("stale_start", eng_start, 1);
    bad = 0;
    for (int i = 1; i <= 13; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) bad++;
      if (i == 3) eng_done = 1'b0;
      if (i == 13) begin eng_r = 18'h15A5A; eng_done = 1'b1; end
    end
    chk("stale_ignored", bad, 0);
    @(posedge clk); #1;
    chk("stale_rsp_valid", rsp_valid, 1);
    chk("stale_rsp_r", rsp_r, 18'h15A5A);
    @(posedge clk); #1;
    eng_done = 1'b0;

    // backpressure
    rsp_ready = 1'b0;
    req_valid = 2'b10; req_func = 4'b1100; req_x = 32'h3333_0000;
    @(posedge clk); #1;
    req_valid = '0;
    chk("bp_start", eng_start, 1);
    repeat (4) @(posedge clk);
    #1 eng_r = 18'h2FEDC; eng_done = 1'b1;
    @(posedge clk); #1;
    chk("bp_rsp_valid", rsp_valid, 1);
    req_valid = 2'b11;
    base = n_start;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_id !== 1'b1 || rsp_func !== 2'd3 || rsp_r !== 18'h2FEDC || rsp_err !== 1'b0) bad++;
      if (req_ready !== 2'b00 || eng_start !== 1'b0) bad++;
    end
    chk("bp_hold", bad, 0);
    chk("bp_no_start", n_start - base, 0);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_busy", busy, 0);
    eng_done = 1'b0;

    // reset in WAIT
    @(posedge clk); #1;
    req_valid = 2'b10; req_func = 4'b1101; req_x = 32'hBEEF_0042;
    @(posedge clk); #1;
    chk("rw_start", eng_start, 1);
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1 base = n_start;
    rst = 1'b0;
    #1;
    chk("rw_req_ready", req_ready, 0);
    chk("rw_busy", busy, 0);
    chk("rw_outputs", {eng_start, eng_func, eng_x, rsp_valid, rsp_id, rsp_func, rsp_r, rsp_err}, 0);
    repeat (2) @(posedge clk);
    #1 chk("rw_no_restart", n_start - base, 0);
    rst = 1'b1;
    #1 chk("rw_prio0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    chk("rw_job_x", eng_x, 16'h0042);
    repeat (2) @(posedge clk);
    #1 eng_done = 1'b1;
    wait_rsp();
    @(posedge clk); #1;
    eng_done = 1'b0;

    // contention from a fresh reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    grants.delete();
    rsps.delete();
    base = n_start;
    req_func = 4'b1001; req_x = 32'h0200_0100;
    req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_start();
      repeat (3) @(posedge clk);
      #1 eng_done = 1'b1;
      wait_rsp();
      if (j == 3) req_valid = '0;
      @(posedge clk); #1;
      eng_done = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 chk("ct_starts", n_start - base, 4);
    chk("ct_ngrants", grants.size(), 4);
    chk("ct_nrsps", rsps.size(), 4);
    for (int j = 0; j < 4 && j < grants.size(); j++) chk("ct_grant", grants[j], (j % 2) ? 2'b10 : 2'b01);
    for (int j = 0; j < 4 && j < rsps.size(); j++) chk("ct_rsp", rsps[j], (j % 2) ? 3'b110 : 3'b001);

`ifdef MACLAUR_TIMEOUT_EN
    @(posedge clk); #1;
    req_valid = 2'b01; req_func = 4'b0011; req_x = 32'h0000_5555;
    @(posedge clk); #1;
    req_valid = '0;
    chk("to_start", eng_start, 1);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (i == 8) chk("to_not_early", rsp_valid, 0);
    end
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_r", rsp_r, 0);
    @(posedge clk); #1;
    eng_done = 1'b1;
    base = n_start;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) bad++;
    end
    chk("to_late_done", bad, 0);
    chk("to_no_start", n_start - base, 0);
    eng_done = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
